// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared helpers for the parametrised synchronous FIFO.
//   FIFO_RD_EMPTY_VAL : bit replicated across o_rd_data while the FIFO is empty
//   fifo_ptr_empty()  : pointers (including wrap bit) identical
//   fifo_ptr_full()   : wrap bits differ, lower AW index bits identical
// Pointers are passed zero-extended to 32 bits so one function serves every
// DEPTH; the caller supplies AW, the number of index bits.
package fifo_pkg;

  localparam bit FIFO_RD_EMPTY_VAL = 1'b0;

  typedef logic [31:0] fifo_ptr_t;

  // Equal pointers mean writer and reader sit on the same lap and slot.
  function automatic logic fifo_ptr_empty(input fifo_ptr_t wrPtr,
                                          input fifo_ptr_t rdPtr);
    return (wrPtr == rdPtr);
  endfunction

  // Same slot but one lap apart: the writer has caught the reader from behind.
  function automatic logic fifo_ptr_full(input fifo_ptr_t   wrPtr,
                                         input fifo_ptr_t   rdPtr,
                                         input int unsigned aw);
    fifo_ptr_t lowMask;
    lowMask = (32'd1 << aw) - 32'd1;
    return (wrPtr[aw] != rdPtr[aw]) && (((wrPtr ^ rdPtr) & lowMask) == 32'd0);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// fifo_ptr_ctr
// PW-bit wrapping pointer register used for both FIFO pointers.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, pointer -> 0
//   i_clr   : synchronous clear, beats i_inc
//   i_inc   : advance pointer by one, wrapping modulo 2^PW
//   o_ptr   : current pointer value
module fifo_ptr_ctr #(
  parameter int unsigned PW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Clear wins over increment so a flush discards any same-cycle access.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register; the natural PW-bit overflow provides the wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO with show-ahead read, occupancy count,
// almost-full/almost-empty thresholds and synchronous flush. Sits between
// instruction-line fetch and decode, or serves as a generic queue.
// Parameters: DEPTH (power of two, >= 2), DATA_WIDTH, AF_THRESH, AE_THRESH.
// Ports:
//   i_clk, i_rst_n          : clock (rising) and async active-low reset
//   i_flush                 : synchronous discard of all entries
//   i_wr_en, i_wr_data      : push request and data
//   i_rd_en                 : pop request
//   o_rd_data               : head entry, 0 while empty
//   o_full, o_empty         : occupancy extremes
//   o_almost_full/_empty    : threshold flags on o_count
//   o_count                 : occupancy 0..DEPTH
//   o_rd_ptr                : read pointer with wrap bit
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky o_overflow/o_underflow,
// cleared only by reset.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [PW-1:0]         o_count,
  output logic [PW-1:0]         o_rd_ptr
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  o_overflow,
  output logic                  o_underflow
`endif
);

  // Thresholds fit in PW bits once the range check below holds.
  localparam logic [PW-1:0] AF_LIMIT = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  // Reject configurations the pointer arithmetic cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthCheck
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH > DEPTH) || (AE_THRESH > DEPTH)) begin : gThreshCheck
    $error("sync_fifo_param: thresholds must lie within 0..DEPTH");
  end

  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic                  wrAcc;
  logic                  rdAcc;
  logic [DATA_WIDTH-1:0] fifoMem_q [DEPTH];

  // Accept decisions use registered flags only; a full FIFO refuses a write
  // even when a pop happens in the same cycle, so there is no pass-through.
  always_comb begin
    wrAcc = i_wr_en & ~o_full  & ~i_flush;
    rdAcc = i_rd_en & ~o_empty & ~i_flush;
  end

  fifo_ptr_ctr #(.PW(PW)) uWrPtr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (wrAcc),
    .o_ptr   (wrPtr)
  );

  fifo_ptr_ctr #(.PW(PW)) uRdPtr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (rdAcc),
    .o_ptr   (rdPtr)
  );

  // Storage is deliberately not reset; the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (wrAcc) begin
      fifoMem_q[wrPtr[AW-1:0]] <= i_wr_data;
    end
  end

  // Flags and count come straight from the registered pointers.
  always_comb begin
    o_empty        = fifo_ptr_empty(32'(wrPtr), 32'(rdPtr));
    o_full         = fifo_ptr_full(32'(wrPtr), 32'(rdPtr), AW);
    o_count        = wrPtr - rdPtr;
    o_almost_full  = (o_count >= AF_LIMIT);
    o_almost_empty = (o_count <= AE_LIMIT);
    o_rd_ptr       = rdPtr;
  end

  // Show-ahead head entry, forced to a known value when nothing is queued.
  always_comb begin
    o_rd_data = {DATA_WIDTH{FIFO_RD_EMPTY_VAL}};
    if (!o_empty) begin
      o_rd_data = fifoMem_q[rdPtr[AW-1:0]];
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky misuse flags; a flush is a legitimate discard, not an error,
  // and it does not clear a previously recorded error either.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (i_wr_en && o_full && !i_flush) begin
        overflow_q <= 1'b1;
      end
      if (i_rd_en && o_empty && !i_flush) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (DEPTH=4, DATA_WIDTH=32).
// A queue holds the data expected at the FIFO head; entries are pushed when
// a write should be accepted and popped when a read should be accepted.
// Define SYNC_FIFO_ERR_FLAGS_EN to also cover the sticky error flags.
module tb_sync_fifo_param;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 3;
  localparam int unsigned AF    = DEPTH - 1;
  localparam int unsigned AE    = 1;

  logic          clk;
  logic          rstN;
  logic          flush;
  logic          wrEn;
  logic [DW-1:0] wrData;
  logic          rdEn;
  logic [DW-1:0] rdData;
  logic          full;
  logic          empty;
  logic          almostFull;
  logic          almostEmpty;
  logic [PW-1:0] count;
  logic [PW-1:0] rdPtr;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int testsRun;
  int testsFailed;

  logic [DW-1:0] expQ[$];
  logic [PW-1:0] modelRdPtr;

  sync_fifo_param #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_flush        (flush),
    .i_wr_en        (wrEn),
    .i_wr_data      (wrData),
    .i_rd_en        (rdEn),
    .o_rd_data      (rdData),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almostFull),
    .o_almost_empty (almostEmpty),
    .o_count        (count),
    .o_rd_ptr       (rdPtr)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .o_overflow     (overflow),
    .o_underflow    (underflow)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every observable output against the bench model.
  task automatic checkState(input string tag);
    int unsigned n;
    logic [DW-1:0] head;
    n    = expQ.size();
    head = (n != 0) ? expQ[0] : '0;
    checkOutput({tag, ".count"},  64'(count),       64'(n));
    checkOutput({tag, ".empty"},  64'(empty),       64'(n == 0));
    checkOutput({tag, ".full"},   64'(full),        64'(n == DEPTH));
    checkOutput({tag, ".afull"},  64'(almostFull),  64'(n >= AF));
    checkOutput({tag, ".aempty"}, 64'(almostEmpty), 64'(n <= AE));
    checkOutput({tag, ".rdptr"},  64'(rdPtr),       64'(modelRdPtr));
    checkOutput({tag, ".rddata"}, 64'(rdData),      64'(head));
  endtask

  // Drive one cycle of stimulus, predict acceptance from the model state,
  // advance through the clock edge and check the resulting outputs.
  task automatic applyStimulus(input string tag, input logic wr,
                               input logic [DW-1:0] data, input logic rd,
                               input logic fl);
    logic wrOk;
    logic rdOk;
    wrEn   = wr;
    wrData = data;
    rdEn   = rd;
    flush  = fl;
    wrOk = wr && (expQ.size() < DEPTH) && !fl;
    rdOk = rd && (expQ.size() != 0) && !fl;
    if (rdOk) begin
      checkOutput({tag, ".pophead"}, 64'(rdData), 64'(expQ[0]));
    end
    @(posedge clk);
    #1;
    if (fl) begin
      expQ.delete();
      modelRdPtr = '0;
    end else begin
      if (rdOk) begin
        void'(expQ.pop_front());
        modelRdPtr = modelRdPtr + 1'b1;
      end
      if (wrOk) begin
        expQ.push_back(data);
      end
    end
    wrEn  = 1'b0;
    rdEn  = 1'b0;
    flush = 1'b0;
    checkState(tag);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelRdPtr  = '0;
    rstN   = 1'b0;
    flush  = 1'b0;
    wrEn   = 1'b0;
    wrData = '0;
    rdEn   = 1'b0;

    // 1: reset state, then a read on an empty FIFO is dropped
    repeat (2) @(posedge clk);
    #1;
    checkState("reset");
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("underflowRd", 1'b0, '0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checkOutput("underflowFlag", 64'(underflow), 64'd1);
    checkOutput("overflowIdle",  64'(overflow),  64'd0);
`endif

    // 2: fill to full, then an extra write is dropped
    applyStimulus("fill0", 1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus("fill1", 1'b1, 32'hB, 1'b0, 1'b0);
    applyStimulus("fill2", 1'b1, 32'hC, 1'b0, 1'b0);
    checkOutput("afAt3", 64'(almostFull), 64'd1);
    applyStimulus("fill3", 1'b1, 32'hD, 1'b0, 1'b0);
    checkOutput("fullAt4", 64'(full), 64'd1);
    applyStimulus("overflowWr", 1'b1, 32'hE, 1'b0, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checkOutput("overflowFlag", 64'(overflow), 64'd1);
`endif
    // full + read + write: the write must still be refused
    applyStimulus("fullRdWr", 1'b1, 32'hF, 1'b1, 1'b0);
    applyStimulus("refill", 1'b1, 32'h10, 1'b0, 1'b0);

    // 3: drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("drain%0d", i), 1'b0, '0, 1'b1, 1'b0);
    end
    checkOutput("drainEmpty", 64'(empty), 64'd1);
    checkOutput("drainData",  64'(rdData), 64'd0);

    // 4: wrap-around with simultaneous read/write at count 2
    applyStimulus("pre0", 1'b1, 32'h100, 1'b0, 1'b0);
    applyStimulus("pre1", 1'b1, 32'h101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("wrap%0d", i), 1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
      checkOutput($sformatf("wrapCnt%0d", i), 64'(count), 64'd2);
    end

    // 5: flush with three entries while writing and reading
    applyStimulus("preFlush", 1'b1, 32'h300, 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 32'hDEAD, 1'b1, 1'b1);
    checkOutput("flushEmpty", 64'(empty), 64'd1);
    checkOutput("flushCount", 64'(count), 64'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checkOutput("flushKeepsOvf", 64'(overflow), 64'd1);
`endif

    // 6: asynchronous reset between clock edges
    applyStimulus("preRst0", 1'b1, 32'h400, 1'b0, 1'b0);
    applyStimulus("preRst1", 1'b1, 32'h401, 1'b0, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    expQ.delete();
    modelRdPtr = '0;
    checkOutput("asyncRstEmpty", 64'(empty), 64'd1);
    checkOutput("asyncRstCount", 64'(count), 64'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checkOutput("asyncRstOvf", 64'(overflow),  64'd0);
    checkOutput("asyncRstUdf", 64'(underflow), 64'd0);
`endif
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("postRst", 1'b1, 32'h55, 1'b0, 1'b0);
    checkOutput("postRstData", 64'(rdData), 64'h55);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
